pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central hazard and stall controller for the five-stage pipeline.
// Produces the PC / IF_ID / ID_EX / EX_MEM / MEM_WB control words each cycle,
// resolving data-memory wait, multi-cycle EX ops, taken branches, load-use
// hazards and instruction-fetch wait in that priority order.
// Optional build macro PIPE_CTRL_PERF_EN adds 64-bit stall and flush counters.

`ifndef CTRL_Wire_Bus
`define CTRL_Wire_Bus 1:0
`endif
`ifndef CTRL_STATE_Default
`define CTRL_STATE_Default 2'b00
`endif
`ifndef CTRL_STATE_Block
`define CTRL_STATE_Block 2'b01
`endif
`ifndef CTRL_STATE_Bubble
`define CTRL_STATE_Bubble 2'b10
`endif

module pipe_ctrl #(
    parameter int unsigned MUL_LAT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           id_rs1_addr_i,
    input  logic [4:0]           id_rs2_addr_i,
    input  logic                 id_rs1_used_i,
    input  logic                 id_rs2_used_i,
    input  logic [6:0]           ex_opcode_i,
    input  logic [4:0]           ex_rd_addr_i,
    input  logic                 ex_wreg_i,
    input  logic                 ex_branch_taken_i,
    input  logic                 ex_mc_start_i,
    input  logic                 mem_busy_i,
    input  logic                 if_busy_i,
    output logic [`CTRL_Wire_Bus] pc_ctrl_o,
    output logic [`CTRL_Wire_Bus] if_id_ctrl_o,
    output logic [`CTRL_Wire_Bus] id_ex_ctrl_o,
    output logic [`CTRL_Wire_Bus] ex_mem_ctrl_o,
    output logic [`CTRL_Wire_Bus] mem_wb_ctrl_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [63:0]          stall_cnt_o,
    output logic [63:0]          flush_cnt_o
`endif
);

    typedef enum logic {
        RUN,
        MC_WAIT
    } state_t;

    // The first stall cycle happens in RUN, so MC_WAIT only needs MUL_LAT-2 more.
    localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 2);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;

    state_t     state, next_state;
    logic [3:0] cnt, next_cnt;
    logic       lu_hazard;
    logic       mc_stall;
    logic       flush_sel;

    // Hazard detection: load-use against the ID operands, and multi-cycle EX occupancy
    always_comb begin
        lu_hazard = (ex_opcode_i == OP_LOAD) && ex_wreg_i && (ex_rd_addr_i != 5'd0) &&
                    ((id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                     (id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i)));
        mc_stall  = ((state == RUN) && ex_mc_start_i) ||
                    ((state == MC_WAIT) && (cnt != 4'd0));
    end

    // Priority resolution of the stage control words; reset forces everything to advance
    always_comb begin
        pc_ctrl_o     = `CTRL_STATE_Default;
        if_id_ctrl_o  = `CTRL_STATE_Default;
        id_ex_ctrl_o  = `CTRL_STATE_Default;
        ex_mem_ctrl_o = `CTRL_STATE_Default;
        mem_wb_ctrl_o = `CTRL_STATE_Default;
        flush_sel     = 1'b0;
        if (rst) begin
            flush_sel = 1'b0;
        end else if (mem_busy_i) begin
            pc_ctrl_o     = `CTRL_STATE_Block;
            if_id_ctrl_o  = `CTRL_STATE_Block;
            id_ex_ctrl_o  = `CTRL_STATE_Block;
            ex_mem_ctrl_o = `CTRL_STATE_Block;
            mem_wb_ctrl_o = `CTRL_STATE_Bubble;
        end else if (mc_stall) begin
            pc_ctrl_o     = `CTRL_STATE_Block;
            if_id_ctrl_o  = `CTRL_STATE_Block;
            id_ex_ctrl_o  = `CTRL_STATE_Block;
            ex_mem_ctrl_o = `CTRL_STATE_Bubble;
        end else if (ex_branch_taken_i) begin
            if_id_ctrl_o  = `CTRL_STATE_Bubble;
            id_ex_ctrl_o  = `CTRL_STATE_Bubble;
            flush_sel     = 1'b1;
        end else if (lu_hazard) begin
            pc_ctrl_o     = `CTRL_STATE_Block;
            if_id_ctrl_o  = `CTRL_STATE_Block;
            id_ex_ctrl_o  = `CTRL_STATE_Bubble;
        end else if (if_busy_i) begin
            pc_ctrl_o     = `CTRL_STATE_Block;
            if_id_ctrl_o  = `CTRL_STATE_Bubble;
        end
    end

    // Next-state logic for the multi-cycle tracker; the countdown runs even under mem_busy
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            RUN: begin
                if (ex_mc_start_i && !mem_busy_i) begin
                    next_state = MC_WAIT;
                    next_cnt   = CNT_LOAD;
                end
            end
            MC_WAIT: begin
                if (cnt != 4'd0) begin
                    next_cnt = cnt - 4'd1;
                end else if (!mem_busy_i) begin
                    next_state = RUN;
                end
            end
            default: begin
                next_state = RUN;
                next_cnt   = 4'd0;
            end
        endcase
    end

    // State and countdown register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    // Saturating performance counters for PC stalls and branch flushes
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= 64'd0;
            flush_cnt_o <= 64'd0;
        end else begin
            if ((pc_ctrl_o == `CTRL_STATE_Block) && (stall_cnt_o != {64{1'b1}})) begin
                stall_cnt_o <= stall_cnt_o + 64'd1;
            end
            if (flush_sel && (flush_cnt_o != {64{1'b1}})) begin
                flush_cnt_o <= flush_cnt_o + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table-driven, scoreboard-checked bench for pipe_ctrl (MUL_LAT = 4).
// Perf counter checks are compiled in when PIPE_CTRL_PERF_EN is defined.

`ifndef CTRL_Wire_Bus
`define CTRL_Wire_Bus 1:0
`endif
`ifndef CTRL_STATE_Default
`define CTRL_STATE_Default 2'b00
`endif
`ifndef CTRL_STATE_Block
`define CTRL_STATE_Block 2'b01
`endif
`ifndef CTRL_STATE_Bubble
`define CTRL_STATE_Bubble 2'b10
`endif

module tb_pipe_ctrl;

    localparam logic [1:0] D = `CTRL_STATE_Default;
    localparam logic [1:0] K = `CTRL_STATE_Block;
    localparam logic [1:0] U = `CTRL_STATE_Bubble;

    localparam logic [9:0] P_DEF = {D, D, D, D, D};
    localparam logic [9:0] P_MEM = {K, K, K, K, U};
    localparam logic [9:0] P_MC  = {K, K, K, U, D};
    localparam logic [9:0] P_BR  = {D, U, U, D, D};
    localparam logic [9:0] P_LU  = {K, K, U, D, D};
    localparam logic [9:0] P_IF  = {K, U, D, D, D};

    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ALU = 7'b0110011;

    typedef struct {
        string      name;
        logic       rst;
        logic [6:0] op;
        logic [4:0] rd;
        logic       wreg;
        logic [4:0] rs1;
        logic       rs1u;
        logic [4:0] rs2;
        logic       rs2u;
        logic       br;
        logic       mc;
        logic       memb;
        logic       ifb;
        logic [9:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic       id_rs1_used, id_rs2_used, ex_wreg, ex_branch_taken, ex_mc_start;
    logic       mem_busy, if_busy;
    logic [6:0] ex_opcode;
    logic [`CTRL_Wire_Bus] pc_ctrl, if_id_ctrl, id_ex_ctrl, ex_mem_ctrl, mem_wb_ctrl;
`ifdef PIPE_CTRL_PERF_EN
    logic [63:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [9:0] expQ[$];
    string      nameQ[$];
    vec_t       tbl[$];

    pipe_ctrl #(.MUL_LAT(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_rs1_addr_i    (id_rs1_addr),
        .id_rs2_addr_i    (id_rs2_addr),
        .id_rs1_used_i    (id_rs1_used),
        .id_rs2_used_i    (id_rs2_used),
        .ex_opcode_i      (ex_opcode),
        .ex_rd_addr_i     (ex_rd_addr),
        .ex_wreg_i        (ex_wreg),
        .ex_branch_taken_i(ex_branch_taken),
        .ex_mc_start_i    (ex_mc_start),
        .mem_busy_i       (mem_busy),
        .if_busy_i        (if_busy),
        .pc_ctrl_o        (pc_ctrl),
        .if_id_ctrl_o     (if_id_ctrl),
        .id_ex_ctrl_o     (id_ex_ctrl),
        .ex_mem_ctrl_o    (ex_mem_ctrl),
        .mem_wb_ctrl_o    (mem_wb_ctrl)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cnt_o      (stall_cnt),
        .flush_cnt_o      (flush_cnt)
`endif
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(input string n, input logic r, input logic [6:0] op,
                                   input logic [4:0] rd, input logic wreg,
                                   input logic [4:0] rs1, input logic rs1u,
                                   input logic [4:0] rs2, input logic rs2u,
                                   input logic br, input logic mc, input logic memb,
                                   input logic ifb, input logic [9:0] exp);
        vec_t v;
        v.name = n; v.rst = r; v.op = op; v.rd = rd; v.wreg = wreg;
        v.rs1 = rs1; v.rs1u = rs1u; v.rs2 = rs2; v.rs2u = rs2u;
        v.br = br; v.mc = mc; v.memb = memb; v.ifb = ifb; v.exp = exp;
        return v;
    endfunction

    // Idle-EX helper: no load in EX, only the control inputs vary
    function automatic vec_t ctl(input string n, input logic r, input logic br,
                                 input logic mc, input logic memb, input logic ifb,
                                 input logic [9:0] exp);
        return mkVec(n, r, ALU, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, br, mc, memb, ifb, exp);
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst             = v.rst;
        ex_opcode       = v.op;
        ex_rd_addr      = v.rd;
        ex_wreg         = v.wreg;
        id_rs1_addr     = v.rs1;
        id_rs1_used     = v.rs1u;
        id_rs2_addr     = v.rs2;
        id_rs2_used     = v.rs2u;
        ex_branch_taken = v.br;
        ex_mc_start     = v.mc;
        mem_busy        = v.memb;
        if_busy         = v.ifb;
        expQ.push_back(v.exp);
        nameQ.push_back(v.name);
    endtask

    task automatic checkOutput();
        logic [9:0] got;
        logic [9:0] exp;
        string      n;
        @(negedge clk);
        got = {pc_ctrl, if_id_ctrl, id_ex_ctrl, ex_mem_ctrl, mem_wb_ctrl};
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty got %b expected a queued entry", got);
        end else begin
            exp = expQ.pop_front();
            n   = nameQ.pop_front();
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL %s got %b expected %b", n, got, exp);
            end
        end
    endtask

    task automatic runVec(input vec_t v);
        applyStimulus(v);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic checkPerf(input string n, input logic [63:0] expStall, input logic [63:0] expFlush);
        checks++;
        if (stall_cnt !== expStall || flush_cnt !== expFlush) begin
            errors++;
            $display("[TB] FAIL %s got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                     n, stall_cnt, flush_cnt, expStall, expFlush);
        end
    endtask
`endif

    initial begin
        // Reset phase: outputs must stay Default even with stall inputs asserted
        runVec(ctl("reset_hold_membusy", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, P_DEF));
        runVec(ctl("reset_hold_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, P_DEF));
        runVec(ctl("after_reset_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_DEF));
`ifdef PIPE_CTRL_PERF_EN
        checkPerf("perf_after_reset", 64'd0, 64'd0);
`endif

        // Branch flush, single cycle
        runVec(ctl("branch_flush", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, P_BR));
        runVec(ctl("branch_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_DEF));
`ifdef PIPE_CTRL_PERF_EN
        checkPerf("perf_flush_count", 64'd0, 64'd1);
`endif

        // if_busy for two cycles
        runVec(ctl("if_busy_1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, P_IF));
        runVec(ctl("if_busy_2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, P_IF));
        runVec(ctl("if_busy_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_DEF));
`ifdef PIPE_CTRL_PERF_EN
        checkPerf("perf_stall_count", 64'd2, 64'd1);
`endif

        // Single-cycle table in RUN state
        tbl.push_back(mkVec("lu_rs2", 1'b0, LD, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, P_LU));
        tbl.push_back(mkVec("lu_released", 1'b0, ALU, 5'd9, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, P_DEF));
        tbl.push_back(mkVec("lu_rd_zero", 1'b0, LD, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, P_DEF));
        tbl.push_back(mkVec("lu_rs1", 1'b0, LD, 5'd7, 1'b1, 5'd7, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, P_LU));
        tbl.push_back(mkVec("lu_rs1_unused", 1'b0, LD, 5'd7, 1'b1, 5'd7, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, P_DEF));
        tbl.push_back(mkVec("lu_rs2_unused", 1'b0, LD, 5'd4, 1'b1, 5'd1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_DEF));
        tbl.push_back(mkVec("lu_no_wreg", 1'b0, LD, 5'd5, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, P_DEF));
        tbl.push_back(mkVec("lu_not_load", 1'b0, ALU, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, P_DEF));
        tbl.push_back(mkVec("branch_over_lu", 1'b0, LD, 5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, P_BR));
        tbl.push_back(mkVec("lu_over_ifbusy", 1'b0, LD, 5'd6, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, P_LU));
        tbl.push_back(mkVec("branch_over_ifbusy", 1'b0, ALU, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, P_BR));
        tbl.push_back(mkVec("mem_over_all", 1'b0, LD, 5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, P_MEM));
        tbl.push_back(mkVec("idle", 1'b0, ALU, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_DEF));
        for (int i = 0; i < tbl.size(); i++) begin
            runVec(tbl[i]);
        end

        // mem_busy for 3 cycles over a pending branch and load-use, then the flush
        for (int i = 0; i < 3; i++) begin
            runVec(mkVec("mem_over_br_lu", 1'b0, LD, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, P_MEM));
        end
        runVec(mkVec("br_after_mem", 1'b0, LD, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, P_BR));
        runVec(ctl("br_after_mem_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_DEF));

        // Multi-cycle op held: three stalls then release
        for (int i = 0; i < 3; i++) begin
            runVec(ctl("mc_stall", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, P_MC));
        end
        runVec(ctl("mc_release", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, P_DEF));
        runVec(ctl("mc_back_run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_DEF));

        // mem_busy overlapping cnt==0 delays the release
        for (int i = 0; i < 3; i++) begin
            runVec(ctl("mc_stall_b", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, P_MC));
        end
        runVec(ctl("mc_cnt0_membusy_1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, P_MEM));
        runVec(ctl("mc_cnt0_membusy_2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, P_MEM));
        runVec(ctl("mc_release_late", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, P_DEF));
        runVec(ctl("mc_late_back_run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_DEF));

        // mem_busy during the countdown still consumes a count
        runVec(ctl("mc_count_start", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, P_MC));
        runVec(ctl("mc_count_membusy", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, P_MEM));
        runVec(ctl("mc_count_cnt1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, P_MC));
        runVec(ctl("mc_count_release", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, P_DEF));
        runVec(ctl("mc_count_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_DEF));

        // Taken branch in the release cycle flushes normally
        for (int i = 0; i < 3; i++) begin
            runVec(ctl("mc_br_stall", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, P_MC));
        end
        runVec(ctl("mc_br_release", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, P_BR));
        runVec(ctl("mc_br_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_DEF));

        // Reset arriving in MC_WAIT with cnt=1
        runVec(ctl("rst_mc_a", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, P_MC));
        runVec(ctl("rst_mc_b", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, P_MC));
        runVec(ctl("rst_mc_cnt1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, P_DEF));
        runVec(ctl("rst_mc_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_DEF));
`ifdef PIPE_CTRL_PERF_EN
        checkPerf("perf_after_mid_reset", 64'd0, 64'd0);
`endif

        // Reset arriving with cnt=2: the countdown must not survive it
        runVec(ctl("rst2_mc_a", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, P_MC));
        runVec(ctl("rst2_mc_cnt2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, P_DEF));
        runVec(ctl("rst2_after_1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_DEF));
        runVec(ctl("rst2_after_2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_DEF));

        // A fresh multi-cycle op after reset gets the full three stalls
        for (int i = 0; i < 3; i++) begin
            runVec(ctl("mc_after_rst", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, P_MC));
        end
        runVec(ctl("mc_after_rst_release", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, P_DEF));
        runVec(ctl("final_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_DEF));

        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_leftover got %0d entries expected 0", expQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
